// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-client memory arbiter.
//   arb_state_e  - arbiter FSM state encoding
//   READ_BEATS   - number of read-enable cycles per block read (4)
//   BEAT_W       - width of the read beat counter
//   calc_addr_w  - word address width derived from memory depth
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int READ_BEATS = 4;
  localparam int BEAT_W     = 2;

  function automatic int calc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: client, status and memory-side signals of mem_arbiter.
//   c0_*/c1_*  - per-client request, write flag, address, write word, done pulse
//   rdata      - last read block, most recently read word in [WIDTH-1:0]
//   busy       - arbiter not idle
//   mem_*      - memory command/response
// Modports: slave = arbiter view, master = clients + memory view.
interface mem_arb_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);
  import mem_arb_pkg::*;

  localparam int ADDR_W = calc_addr_w(DEPTH);

  logic                  c0_req;
  logic                  c0_we;
  logic [ADDR_W-1:0]     c0_addr;
  logic [WIDTH-1:0]      c0_wdata;
  logic                  c0_done;
  logic                  c1_req;
  logic                  c1_we;
  logic [ADDR_W-1:0]     c1_addr;
  logic [WIDTH-1:0]      c1_wdata;
  logic                  c1_done;
  logic [WIDTH*4-1:0]    rdata;
  logic                  busy;
  logic [ADDR_W-1:0]     mem_address;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [WIDTH-1:0]      mem_write_data;
  logic                  mem_ready;
  logic [WIDTH*4-1:0]    mem_read_data;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c0_done, c1_done, rdata, busy,
    output mem_address, mem_write_en, mem_read_en, mem_write_data,
    input  mem_ready, mem_read_data
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c0_done, c1_done, rdata, busy,
    input  mem_address, mem_write_en, mem_read_en, mem_write_data,
    output mem_ready, mem_read_data
  );

endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks which client is granted when the arbiter is idle.
//   req_i      - {c1_req, c0_req}
//   gnt_vld_o  - at least one request present
//   gnt_idx_o  - granted client (0 or 1)
// Build option MEM_ARB_RR_EN: round-robin between simultaneous requests
// (adds clk/reset/take_i and a last-grant pointer). Without it client 0
// always wins and no state exists.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       take_i,
`endif
  input  logic [1:0] req_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  assign gnt_vld_o = |req_i;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (take_i && gnt_vld_o) last_d = gnt_idx_o;
  end

  // pointer starts at client 1 so the first contested grant goes to client 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign gnt_idx_o = (&req_i) ? ~last_q : req_i[1];
`else
  assign gnt_idx_o = ~req_i[0];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client arbiter in front of a single-port block memory.
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   bus    - mem_arb_if.slave: client handshakes, rdata, busy, memory port
// A write issues one mem_write_en cycle; a read issues four mem_read_en
// cycles and captures the whole block when mem_ready arrives.
// Build option MEM_ARB_RR_EN: round-robin grant instead of fixed priority.
//
// state    | meaning
// ST_IDLE  | sample requests, latch the granted command
// ST_ISSUE | drive write enable 1 cycle or read enable 4 cycles
// ST_WAIT  | wait for mem_ready, capture read block
// ST_DONE  | pulse the granted client's done
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic      clk,
  input  logic      reset,
  mem_arb_if.slave  bus
);

  localparam int ADDR_W = calc_addr_w(DEPTH);

  arb_state_e                    state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic                          gnt_q, gnt_d;
  logic                          we_q, we_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [WIDTH-1:0]              wdata_q, wdata_d;
  logic [READ_BEATS*WIDTH-1:0]   rdata_q, rdata_d;
  logic                          gnt_vld;
  logic                          gnt_idx;

`ifdef MEM_ARB_RR_EN
  mem_arb_grant u_grant (
    .clk       (clk),
    .reset     (reset),
    .take_i    (state_q == ST_IDLE),
    .req_i     ({bus.c1_req, bus.c0_req}),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );
`else
  mem_arb_grant u_grant (
    .req_i     ({bus.c1_req, bus.c0_req}),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          gnt_d   = gnt_idx;
          we_d    = gnt_idx ? bus.c1_we    : bus.c0_we;
          addr_d  = gnt_idx ? bus.c1_addr  : bus.c0_addr;
          wdata_d = gnt_idx ? bus.c1_wdata : bus.c0_wdata;
          // read beats run as a down-counter ending at zero
          beat_d  = we_d ? '0 : BEAT_W'(READ_BEATS - 1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q || beat_q == '0) state_d = ST_WAIT;
        else                      beat_d  = beat_q - 1'b1;
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          if (!we_q) rdata_d = bus.mem_read_data;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // memory side comes only from latched command registers
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_write_en   = (state_q == ST_ISSUE) &&  we_q;
  assign bus.mem_read_en    = (state_q == ST_ISSUE) && !we_q;

  assign bus.c0_done = (state_q == ST_DONE) && !gnt_q;
  assign bus.c1_done = (state_q == ST_DONE) &&  gnt_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural
// block memory (one-cycle ready delay, reads shift words in from the top
// of the block down so the lowest word ends in [WIDTH-1:0]).
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int AW = 10;
  localparam int BW = 4 * W;

  typedef struct {
    logic          cl;
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [BW-1:0] rdata;
    int            done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t          sb_q[$];
  logic [W-1:0]  shadow [D];
  logic [BW-1:0] sh_rdata = '0;

  mem_arb_if #(.WIDTH(W), .DEPTH(D)) bus ();

  mem_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [W-1:0]  mem [D];
  logic [1:0]    m_beat;
  logic          m_pend;
  logic [BW-1:0] m_sh = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_beat        <= 2'd0;
      m_pend        <= 1'b0;
      bus.mem_ready <= 1'b0;
    end else if (bus.mem_write_en) begin
      mem[bus.mem_address] <= bus.mem_write_data;
      m_pend        <= 1'b1;
      bus.mem_ready <= 1'b0;
    end else if (bus.mem_read_en) begin
      m_sh   <= {m_sh[BW-W-1:0], mem[{bus.mem_address[AW-1:2], 2'd3 - m_beat}]};
      m_beat <= m_beat + 2'd1;
      m_pend <= 1'b1;
    end else if (m_pend) begin
      bus.mem_ready <= 1'b1;
      m_pend        <= 1'b0;
      m_beat        <= 2'd0;
    end else begin
      bus.mem_ready <= 1'b0;
    end
  end

  assign bus.mem_read_data = m_sh;

  // ---------------- monitor / scoreboard ----------------
  int rd_run = 0;
  int wr_run = 0;
  int dn_run = 0;

  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      rd_run <= 0;
      wr_run <= 0;
      dn_run <= 0;
    end else begin
      chk("we_re_excl", 128'(bus.mem_write_en & bus.mem_read_en), 128'(0));
      chk("both_done", 128'(bus.c0_done & bus.c1_done), 128'(0));
      if (bus.mem_read_en) rd_run <= rd_run + 1;
      else begin
        if (rd_run != 0) chk("rd_run_len", 128'(rd_run), 128'(4));
        rd_run <= 0;
      end
      if (bus.mem_write_en) wr_run <= wr_run + 1;
      else begin
        if (wr_run != 0) chk("wr_run_len", 128'(wr_run), 128'(1));
        wr_run <= 0;
      end
      if (bus.c0_done || bus.c1_done) dn_run <= dn_run + 1;
      else begin
        if (dn_run != 0) chk("done_len", 128'(dn_run), 128'(1));
        dn_run <= 0;
      end
      if (bus.mem_read_en && rd_run == 0 && sb_q.size() > 0)
        chk("rd_addr", 128'(bus.mem_address), 128'(sb_q[0].addr));
      if (bus.mem_write_en && sb_q.size() > 0) begin
        chk("wr_addr", 128'(bus.mem_address), 128'(sb_q[0].addr));
        chk("wr_data", 128'(bus.mem_write_data), 128'(sb_q[0].wdata));
      end
      if (bus.c0_done || bus.c1_done) begin
        if (sb_q.size() == 0) chk("unexp_done", 128'(sb_q.size()), 128'(1));
        else begin
          e = sb_q.pop_front();
          chk("done_client", 128'(bus.c1_done), 128'(e.cl));
          chk("done_cyc", 128'(cyc), 128'(e.done_cyc));
          chk("rdata", 128'(bus.rdata), 128'(e.rdata));
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = {a[AW-1:2], 2'b00};
    return {shadow[b + 10'd3], shadow[b + 10'd2], shadow[b + 10'd1], shadow[b]};
  endfunction

  task automatic drive(input bit cl, input bit r, input bit we, input logic [AW-1:0] a,
                       input logic [W-1:0] d);
    if (cl) begin
      bus.c1_req = r; bus.c1_we = we; bus.c1_addr = a; bus.c1_wdata = d;
    end else begin
      bus.c0_req = r; bus.c0_we = we; bus.c0_addr = a; bus.c0_wdata = d;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 128'(bus.busy), 128'(0));
  endtask

  function automatic exp_t mk(input bit cl, input bit we, input logic [AW-1:0] a,
                              input logic [W-1:0] d, input int done_cyc);
    exp_t e;
    e.cl = cl; e.we = we; e.addr = a; e.wdata = d; e.done_cyc = done_cyc;
    if (we) shadow[a] = d;
    else    sh_rdata = blk(a);
    e.rdata = sh_rdata;
    return e;
  endfunction

  task automatic do_txn(input bit cl, input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
    int n = 0;
    logic seen;
    wait_idle();
    sb_q.push_back(mk(cl, we, a, d, cyc + 1 + (we ? 3 : 6)));
    drive(cl, 1'b1, we, a, d);
    do begin
      @(negedge clk);
      n++;
      seen = cl ? bus.c1_done : bus.c0_done;
    end while (!seen && n < 30);
    chk("txn_done_seen", 128'(seen), 128'(1));
    drive(cl, 1'b0, we, a, d);
  endtask

  task automatic simul();
    int c;
    int got = 0;
    int n = 0;
    wait_idle();
    c = cyc;
    sb_q.push_back(mk(1'b0, 1'b1, 10'h3F0, 32'h1111_0000, c + 4));
`ifdef MEM_ARB_RR_EN
    sb_q.push_back(mk(1'b1, 1'b1, 10'h3F4, 32'h2222_0000, c + 9));
`else
    sb_q.push_back(mk(1'b0, 1'b1, 10'h3F0, 32'h1111_0000, c + 9));
`endif
    drive(1'b0, 1'b1, 1'b1, 10'h3F0, 32'h1111_0000);
    drive(1'b1, 1'b1, 1'b1, 10'h3F4, 32'h2222_0000);
    while (got < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.c0_done || bus.c1_done) got++;
    end
    chk("simul_dones", 128'(got), 128'(2));
    drive(1'b0, 1'b0, 1'b1, 10'h3F0, 32'h1111_0000);
    drive(1'b1, 1'b0, 1'b1, 10'h3F4, 32'h2222_0000);
  endtask

  task automatic reset_test();
    wait_idle();
    sb_q.push_back(mk(1'b1, 1'b0, 10'h020, '0, cyc + 7));
    drive(1'b1, 1'b1, 1'b0, 10'h020, '0);
    @(negedge clk);
    chk("rst_pre_re", 128'(bus.mem_read_en), 128'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_re", 128'(bus.mem_read_en), 128'(0));
    chk("rst_we", 128'(bus.mem_write_en), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.c1_done), 128'(0));
    chk("rst_rdata", 128'(bus.rdata), 128'(0));
    drive(1'b1, 1'b0, 1'b0, 10'h020, '0);
    void'(sb_q.pop_back());
    sh_rdata = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_done_after_rst", 128'(bus.c0_done | bus.c1_done), 128'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_we", 128'(bus.mem_write_en), 128'(0));
    chk("reset_re", 128'(bus.mem_read_en), 128'(0));
    chk("reset_done", 128'({bus.c1_done, bus.c0_done}), 128'(0));
    chk("reset_rdata", 128'(bus.rdata), 128'(0));
    chk("reset_addr", 128'(bus.mem_address), 128'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    do_txn(1'b0, 1'b1, 10'h010, 32'hDEAD_BEEF);

    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] base;
      base = AW'($urandom_range(8, 200) * 4);
      for (int j = 0; j < 4; j++)
        do_txn(1'($urandom_range(0, 1)), 1'b1, base + AW'(j), $urandom);
      do_txn(1'($urandom_range(0, 1)), 1'b0, base + AW'($urandom_range(0, 3)), '0);
    end

    for (int j = 0; j < 4; j++)
      do_txn(1'b1, 1'b1, 10'h010 + AW'(j), W'(j + 1));
    do_txn(1'b1, 1'b0, 10'h013, '0);
    chk("req027_rdata", 128'(bus.rdata), {32'd4, 32'd3, 32'd2, 32'd1});

    simul();
    reset_test();
    do_txn(1'b0, 1'b1, 10'h030, 32'hCAFE_0001);

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, memory word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, memory depth in words; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have ports clk  in  1  system clock; reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have, per client i in {0,1}: ci_req  in  1  request, held until ci_done; ci_we  in  1  1=word write, 0=block read; ci_addr  in  ADDR_W  word address; ci_wdata  in  WIDTH  write word; ci_done  out  1  one-cycle completion pulse.
REQ-005 SHALL have rdata  out  WIDTH*4  read block, most recently read word in [WIDTH-1:0].
REQ-006 SHALL have busy  out  1  high in every state except IDLE.
REQ-007 SHALL have mem_address  out  ADDR_W;  mem_write_en  out  1;  mem_read_en  out  1;  mem_write_data  out  WIDTH;  mem_ready  in  1;  mem_read_data  in  WIDTH*4.

Function
REQ-008 SHALL use FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-009 In IDLE, SHALL sample c0_req/c1_req on each edge; if any is high, grant one, latch its we/addr/wdata into registers, go to ISSUE.
REQ-010 SHALL drive mem_* from the latched registers only, never combinationally from client inputs.
REQ-011 In ISSUE, SHALL assert exactly one of mem_write_en/mem_read_en: 1 cycle for a write, exactly 4 cycles for a read (2-bit beat counter), then go to WAIT.
REQ-012 SHALL never assert mem_write_en and mem_read_en together, and SHALL hold both low in IDLE, WAIT and DONE.
REQ-013 In WAIT, SHALL remain until mem_ready=1; on that edge, for reads, register mem_read_data into rdata, then go to DONE.
REQ-014 In DONE, SHALL assert the granted ci_done for exactly one cycle, then go to IDLE.
REQ-015 rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-016 Latency from request-sampling edge to ci_done high: read 6 cycles, write 3 cycles; back-to-back transactions SHALL be separated by one IDLE cycle.
REQ-017 A ci_req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-018 A ci_req dropped mid-transaction SHALL NOT abort it; ci_done SHALL still pulse.
REQ-019 Read mem_address SHALL be passed unmodified; the memory selects block words from address[ADDR_W-1:2].

Reset
REQ-020 On reset low, SHALL immediately enter IDLE and clear all outputs to 0, rdata to 0, beat counter to 0, and last-grant pointer to client 1.
REQ-021 Reset asserted mid-transaction SHALL abort it with no ci_done pulse.

Configuration
REQ-022 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the client not granted last wins; the pointer updates on each grant.
REQ-023 With MEM_ARB_RR_EN undefined, client 0 SHALL always win simultaneous requests, and the pointer logic SHALL be absent.

Structure
REQ-024 SHALL place FSM state encoding, the read beat count (4) and ADDR_W derivation in shared package mem_arb_pkg.
REQ-025 SHALL place grant selection (fixed/round-robin) in one sub-module mem_arb_grant; everything else SHALL stay in mem_arbiter.

Verification
REQ-026 Client 0 writes addr 0x010, data 0xDEADBEEF -> mem_write_en high 1 cycle with mem_address 0x010; c0_done 3 cycles after sampling; rdata unchanged.
REQ-027 Client 1 reads addr 0x013 after preloading words 0x010..0x013 with 1,2,3,4 -> mem_read_en high exactly 4 cycles; c1_done after 6 cycles; rdata = {4,3,2,1} per memory shift order.
REQ-028 c0_req and c1_req high together twice in a row, RR enabled -> grants 0 then 1; RR disabled -> grants 0 then 0 while c0_req is held.
REQ-029 Reset pulsed during ISSUE of a read -> enables low immediately, no ci_done, busy=0; a subsequent write completes normally.
REQ-030 Assertion for the entire run: mem_write_en & mem_read_en never 1; read_en high-run length is exactly 4; a ci_done pulse is exactly 1 cycle.
